zero_detect_pipe: RTL and testbench
===================================

# zero_detect_pipe

Parametrised, pipelined zero detector for the arithmetics library. It reduces a WIDTH-bit operand through a binary AND/OR tree and reports whether the operand is all zeros. Optionally it also reports a leading-zero count. Tree levels are grouped into register stages, and a valid/ready handshake gives full throughput with backpressure. It replaces the fixed 8-bit combinational zero test wherever wide operands or timing closure need a registered result.

## Interface
- WIDTH, 32: operand width; power of two, 2..256.
- LEVELS_PER_STAGE, 1: tree levels between pipeline registers, 1..log2(WIDTH).
- TAG_W, 4: sideband tag width, ≥1; carried alongside the operand, never modified.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  operand present.
- o_ready  out  1  block accepts an operand this cycle.
- i_a  in  WIDTH  operand.
- i_tag  in  TAG_W  sideband.
- o_valid  out  1  result present.
- i_ready  in  1  consumer accepts the result.
- o_zero  out  1  1 when the accepted i_a was all zeros.
- o_lzc  out  log2(WIDTH)+1  leading-zero count from the MSB; present only with ZERO_DETECT_LZC_EN.
- o_tag  out  TAG_W  tag accepted with the operand.

## Operation
- Tree has LEVELS = log2(WIDTH) levels.
- Level 0 leaf per bit: z = ~a[i], cnt = z.
- Each node combines a high child h and a low child l, each covering n bits:
  - z = z_h & z_l
  - cnt = z_h ? n + cnt_l : cnt_h
  - cnt widens by 1 bit per level.
- Root gives o_zero = z and o_lzc = cnt. An all-zero operand gives lzc = WIDTH.
- Pipeline has S = ceil(LEVELS/LEVELS_PER_STAGE) stages. Stage k registers the node vector after its levels, the tag, and valid_k.
- Advance rules:
  - adv_last = ~valid_last | i_ready
  - adv_k = ~valid_k | adv_{k+1}
  - When adv_k holds, stage k loads from stage k-1 (stage 0 loads from i_a/i_valid).
  - o_ready = adv_0. This is a combinational chain from i_ready, with no skid buffer.
- Transfers happen only on a handshake:
  - Input transfer: i_valid & o_ready.
  - Output transfer: o_valid & i_ready.
- Stalled stages hold their contents; no result is lost or duplicated.
- Bubbles collapse: an empty stage loads even while downstream is stalled.
- Results leave in acceptance order. The tag always stays aligned with its operand.

## Timing
- Latency is S cycles from input transfer to o_valid. Examples:
  - WIDTH=32, LEVELS_PER_STAGE=1: 5 cycles.
  - WIDTH=8, LEVELS_PER_STAGE=3: 1 cycle.
- Throughput is one operand per cycle while i_ready=1.
- Reset values: o_valid=0, o_zero=0, o_lzc=0, o_tag=0, all valid_k=0, all stage data registers 0. o_ready follows as 1 once reset deasserts.
- Reset mid-operation discards all in-flight results. No output transfer happens after reset asserts.
- Outputs are held stable while o_valid=1 & i_ready=0.
- i_ready may toggle when o_valid=0; this has no effect on state.
- Simultaneous output and input transfer with a full pipeline is legal and keeps throughput.
- Inputs are ignored while i_valid=0; stage 0 becomes a bubble.

## Configuration
- ZERO_DETECT_LZC_EN defined: cnt fields are built and registered at every stage, and the o_lzc port exists.
- Macro undefined:
  - Only z bits and the tag are registered; o_lzc is absent from the port list.
  - o_zero, handshake and latency are identical to the defined case.

## Structure
- Package zero_detect_pkg holds:
  - the clog2 function
  - the LZC_W(WIDTH) = clog2(WIDTH)+1 constant function
  - the stage-count function S(WIDTH, LEVELS_PER_STAGE)
- Sub-module zd_node combines two children into one parent (z, cnt).
  - Parametrised by child span n.
  - Instantiated by generate loops per level.
  - Its cnt logic is removed when ZERO_DETECT_LZC_EN is undefined.

## Test plan
- Reset values, WIDTH=32, LEVELS_PER_STAGE=1: assert i_rst with i_valid=1, i_a=0 -> o_valid=0, o_zero=0, o_tag=0 throughout reset; release -> o_ready=1.
- Basic detection: i_a=0x00000000 tag 3, then 0x80000000 tag 4, then 0x00000001 tag 5, i_ready=1 -> five cycles later, three consecutive results:
  - o_zero=1, lzc=32, tag 3
  - o_zero=0, lzc=0, tag 4
  - o_zero=0, lzc=31, tag 5
- Backpressure with random i_valid/i_ready over 1000 operands -> output sequence matches input order exactly; no drops or duplicates; outputs stable while stalled.
- Bubble collapse: single operand 0x00010000 with i_ready=0 -> it reaches the last stage; other stages stay empty, o_ready=1; release i_ready -> one transfer with lzc=15.
- Reset mid-stream: pipeline full, assert i_rst for 1 cycle -> o_valid=0 immediately; no stale result appears afterwards.
- Configuration sweep: WIDTH=8, LEVELS_PER_STAGE=3, both with and without ZERO_DETECT_LZC_EN -> latency 1; exhaustive 256 operands give correct o_zero, and correct lzc when the macro is enabled.

Source files
------------

// File: rtl/zero_detect_pkg.sv
// Shared sizing helpers for the pipelined zero detector.
// Leading-zero count support is selected with ZERO_DETECT_LZC_EN.
package zero_detect_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned lzc_w(input int unsigned width);
    return clog2(width) + 1;
  endfunction

  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/zero_detect_pipe_if.sv
// Operand/result handshake bundle for zero_detect_pipe.
// o_lzc exists only when ZERO_DETECT_LZC_EN is defined.
interface zero_detect_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  import zero_detect_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;
`ifdef ZERO_DETECT_LZC_EN
  logic [lzc_w(WIDTH)-1:0] o_lzc;
`endif

  modport master (
    output i_valid, i_a, i_tag, i_ready,
    input  o_ready, o_valid, o_zero, o_tag
`ifdef ZERO_DETECT_LZC_EN
    , input o_lzc
`endif
  );

  modport slave (
    input  i_valid, i_a, i_tag, i_ready,
    output o_ready, o_valid, o_zero, o_tag
`ifdef ZERO_DETECT_LZC_EN
    , output o_lzc
`endif
  );

endinterface

// File: rtl/zd_node.sv
// Merges two zero-detect children, each spanning N bits, into their parent.
// With ZERO_DETECT_LZC_EN the leading-zero counts are merged as well.
module zd_node
  import zero_detect_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  logic                z_h_i,
  input  logic                z_l_i,
`ifdef ZERO_DETECT_LZC_EN
  input  logic [clog2(N):0]   cnt_h_i,
  input  logic [clog2(N):0]   cnt_l_i,
  output logic [clog2(N)+1:0] cnt_o,
`endif
  output logic                z_o
);

  if (N == 0 || (N & (N - 1)) != 0) begin : g_chk
    $error("zd_node: child span N must be a power of two");
  end

  assign z_o = z_h_i & z_l_i;

`ifdef ZERO_DETECT_LZC_EN
  localparam int unsigned CW = clog2(N) + 1;

  // An all-zero high child contributes its whole span, counting continues in the low child.
  assign cnt_o = z_h_i ? ((CW + 1)'(N) + {1'b0, cnt_l_i}) : {1'b0, cnt_h_i};
`endif

endmodule

// File: rtl/zero_detect_pipe.sv
// Pipelined WIDTH-bit zero detector: binary AND tree, registered every
// LEVELS_PER_STAGE levels, valid/ready handshake; ZERO_DETECT_LZC_EN adds o_lzc.
module zero_detect_pipe
  import zero_detect_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned LEVELS_PER_STAGE = 1,
  parameter int unsigned TAG_W            = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  zero_detect_pipe_if.slave bus
);

  localparam int unsigned LEVELS = clog2(WIDTH);
  localparam int unsigned S      = num_stages(WIDTH, LEVELS_PER_STAGE);

  if (WIDTH < 2 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0) begin : g_chk_w
    $error("zero_detect_pipe: WIDTH must be a power of two in 2..256");
  end
  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > LEVELS) begin : g_chk_l
    $error("zero_detect_pipe: LEVELS_PER_STAGE must be in 1..log2(WIDTH)");
  end

  // Per-stage control: valid, tag and the advance chain back from i_ready.
  for (genvar k = 0; k < S; k++) begin : stg
    logic             vld_q;
    logic             vld_d;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_d;
    logic             adv;

    if (k == 0) begin : g_src
      assign vld_d = bus.i_valid;
      assign tag_d = bus.i_tag;
    end else begin : g_src
      assign vld_d = stg[k-1].vld_q;
      assign tag_d = stg[k-1].tag_q;
    end

    if (k == S - 1) begin : g_adv
      assign adv = ~vld_q | bus.i_ready;
    end else begin : g_adv
      assign adv = ~vld_q | stg[k+1].adv;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q <= 1'b0;
        tag_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        tag_q <= tag_d;
      end
    end
  end

  // Tree levels; level l holds WIDTH>>l nodes, each z plus an (l+1)-bit count.
  for (genvar l = 0; l <= LEVELS; l++) begin : lv
    localparam int unsigned NW = WIDTH >> l;
`ifdef ZERO_DETECT_LZC_EN
    localparam int unsigned CW = l + 1;
    logic [NW*CW-1:0] c;
`endif
    logic [NW-1:0]    z;

    if (l == 0) begin : g_leaf
      assign z = ~bus.i_a;
`ifdef ZERO_DETECT_LZC_EN
      assign c = ~bus.i_a;
`endif
    end else begin : g_node
      localparam int unsigned K  = (l - 1) / LEVELS_PER_STAGE;
      localparam int unsigned CH = 1 << (l - 1);
      logic [NW-1:0]    z_d;
`ifdef ZERO_DETECT_LZC_EN
      logic [NW*CW-1:0] c_d;
`endif

      for (genvar j = 0; j < NW; j++) begin : nd
        zd_node #(.N(CH)) u_node (
          .z_h_i  (lv[l-1].z[2*j+1]),
          .z_l_i  (lv[l-1].z[2*j]),
`ifdef ZERO_DETECT_LZC_EN
          .cnt_h_i(lv[l-1].c[(2*j+1)*l +: l]),
          .cnt_l_i(lv[l-1].c[(2*j)*l +: l]),
          .cnt_o  (c_d[j*CW +: CW]),
`endif
          .z_o    (z_d[j])
        );
      end

      // The last level of each stage group is registered under that stage's advance.
      if ((l % LEVELS_PER_STAGE) == 0 || l == LEVELS) begin : g_reg
        logic [NW-1:0]    z_q;
`ifdef ZERO_DETECT_LZC_EN
        logic [NW*CW-1:0] c_q;
`endif
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            z_q <= '0;
`ifdef ZERO_DETECT_LZC_EN
            c_q <= '0;
`endif
          end else if (stg[K].adv) begin
            z_q <= z_d;
`ifdef ZERO_DETECT_LZC_EN
            c_q <= c_d;
`endif
          end
        end
        assign z = z_q;
`ifdef ZERO_DETECT_LZC_EN
        assign c = c_q;
`endif
      end else begin : g_comb
        assign z = z_d;
`ifdef ZERO_DETECT_LZC_EN
        assign c = c_d;
`endif
      end
    end
  end

  assign bus.o_ready = stg[0].adv;
  assign bus.o_valid = stg[S-1].vld_q;
  assign bus.o_tag   = stg[S-1].tag_q;
  assign bus.o_zero  = lv[LEVELS].z[0];
`ifdef ZERO_DETECT_LZC_EN
  assign bus.o_lzc   = lv[LEVELS].c;
`endif

endmodule

// File: tb/tb_zero_detect_pipe.sv
// Self-checking bench for zero_detect_pipe: 32-bit/1-level and 8-bit/3-level
// instances against a queue-based reference; lzc checked with ZERO_DETECT_LZC_EN.
module tb_zero_detect_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zero_detect_pipe_if #(.WIDTH(32), .TAG_W(4)) b32 ();
  zero_detect_pipe_if #(.WIDTH(8),  .TAG_W(4)) b8 ();

  zero_detect_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(4)) dut32 (
    .i_clk(clk), .i_rst(rst), .bus(b32.slave));
  zero_detect_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(3), .TAG_W(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(b8.slave));

  typedef struct {
    logic       z;
    int         lzc;
    logic [3:0] tag;
    int         acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   nvec    = 0;
  int   nerr    = 0;
  int   cyc     = 0;
  bit   chk_lat = 0;
  int   lat_exp = 0;
  bit   stall32 = 0;
  logic       sv_zero;
  logic [3:0] sv_tag;
`ifdef ZERO_DETECT_LZC_EN
  logic [5:0] sv_lzc;
`endif

  // Leading zeros counted from bit w-1 downward.
  function automatic int ref_lzc(input logic [31:0] a, input int w);
    int n;
    n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (a[i]) return n;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step32(input logic v, input logic [31:0] a, input logic [3:0] t,
                        input logic rdy, output logic acc, output logic rdy_o,
                        output logic vld_o);
    exp_t e;
    @(negedge clk);
    b32.i_valid = v;
    b32.i_a     = a;
    b32.i_tag   = t;
    b32.i_ready = rdy;
    #1;
    rdy_o = b32.o_ready;
    vld_o = b32.o_valid;
    if (stall32) begin
      chk("stall_valid", b32.o_valid, 1);
      chk("stall_zero", b32.o_zero, sv_zero);
      chk("stall_tag", b32.o_tag, sv_tag);
`ifdef ZERO_DETECT_LZC_EN
      chk("stall_lzc", b32.o_lzc, sv_lzc);
`endif
    end
    if (q32.size() == 0) chk("idle_valid32", vld_o, 0);
    else if (vld_o) begin
      chk("zero32", b32.o_zero, q32[0].z);
      chk("tag32", b32.o_tag, q32[0].tag);
`ifdef ZERO_DETECT_LZC_EN
      chk("lzc32", b32.o_lzc, q32[0].lzc);
`endif
      if (chk_lat && rdy) chk("latency32", cyc - q32[0].acc, lat_exp);
    end
    stall32 = vld_o & ~rdy;
    sv_zero = b32.o_zero;
    sv_tag  = b32.o_tag;
`ifdef ZERO_DETECT_LZC_EN
    sv_lzc  = b32.o_lzc;
`endif
    acc = v & rdy_o;
    @(posedge clk);
    if (vld_o && rdy && q32.size() > 0) void'(q32.pop_front());
    if (acc) begin
      e.z = (a == 32'd0); e.lzc = ref_lzc(a, 32); e.tag = t; e.acc = cyc;
      q32.push_back(e);
    end
    cyc++;
  endtask

  task automatic step8(input logic v, input logic [7:0] a, input logic [3:0] t);
    exp_t e;
    logic acc, vo;
    @(negedge clk);
    b8.i_valid = v;
    b8.i_a     = a;
    b8.i_tag   = t;
    b8.i_ready = 1'b1;
    #1;
    vo = b8.o_valid;
    if (q8.size() == 0) chk("idle_valid8", vo, 0);
    else if (vo) begin
      chk("zero8", b8.o_zero, q8[0].z);
      chk("tag8", b8.o_tag, q8[0].tag);
`ifdef ZERO_DETECT_LZC_EN
      chk("lzc8", b8.o_lzc, q8[0].lzc);
`endif
      if (chk_lat) chk("latency8", cyc - q8[0].acc, lat_exp);
    end
    acc = v & b8.o_ready;
    @(posedge clk);
    if (vo && q8.size() > 0) void'(q8.pop_front());
    if (acc) begin
      e.z = (a == 8'd0); e.lzc = ref_lzc({24'd0, a}, 8); e.tag = t; e.acc = cyc;
      q8.push_back(e);
    end
    cyc++;
  endtask

  task automatic drain32(input int maxc);
    logic acc, rdy, vld;
    for (int i = 0; i < maxc && q32.size() > 0; i++) step32(0, '0, '0, 1, acc, rdy, vld);
    chk("drain32_empty", q32.size(), 0);
    repeat (6) step32(0, '0, '0, 1, acc, rdy, vld);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc, rdy, vld;
    int   n;
    logic [31:0] a;

    b32.i_valid = 1'b1; b32.i_a = '0; b32.i_tag = 4'hA; b32.i_ready = 1'b1;
    b8.i_valid  = 1'b1; b8.i_a  = '0; b8.i_tag  = 4'h6; b8.i_ready  = 1'b1;

    // Reset held with a valid zero operand on the inputs.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_valid", b32.o_valid, 0);
      chk("rst_zero", b32.o_zero, 0);
      chk("rst_tag", b32.o_tag, 0);
`ifdef ZERO_DETECT_LZC_EN
      chk("rst_lzc", b32.o_lzc, 0);
`endif
      chk("rst_valid8", b8.o_valid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    b32.i_valid = 1'b0;
    b8.i_valid  = 1'b0;
    #1;
    chk("rst_ready", b32.o_ready, 1);
    chk("rst_ready8", b8.o_ready, 1);

    // Basic detection, back-to-back, latency 5.
    chk_lat = 1; lat_exp = 5;
    step32(1, 32'h0000_0000, 4'd3, 1, acc, rdy, vld);
    step32(1, 32'h8000_0000, 4'd4, 1, acc, rdy, vld);
    step32(1, 32'h0000_0001, 4'd5, 1, acc, rdy, vld);
    drain32(20);
    chk_lat = 0;

    // Random valid/ready over 1000 accepted operands.
    n = 0;
    for (int c = 0; c < 6000 && n < 1000; c++) begin
      a = $urandom >> $urandom_range(0, 32);
      step32($urandom_range(0, 9) < 7, a, 4'($urandom), $urandom_range(0, 9) < 6,
             acc, rdy, vld);
      if (acc) n++;
    end
    chk("rand_accepted", n, 1000);
    drain32(60);

    // Bubble collapse: one operand runs to the last stage under backpressure.
    step32(1, 32'h0001_0000, 4'h9, 0, acc, rdy, vld);
    chk("bub_accept", acc, 1);
    repeat (6) step32(0, '0, '0, 0, acc, rdy, vld);
    chk("bub_valid", vld, 1);
    chk("bub_ready", rdy, 1);
    chk("bub_model_lzc", q32[0].lzc, 15);
    step32(0, '0, '0, 1, acc, rdy, vld);
    chk("bub_out", vld, 1);
    drain32(10);

    // Mid-stream reset with a full, stalled pipeline.
    for (int i = 0; i < 8; i++) step32(1, $urandom, 4'(i), 0, acc, rdy, vld);
    chk("full_ready", rdy, 0);
    chk("full_valid", vld, 1);
    @(negedge clk);
    rst = 1'b1;
    b32.i_valid = 1'b0;
    #1;
    chk("mid_rst_valid", b32.o_valid, 0);
    q32.delete();
    stall32 = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) step32(0, '0, '0, 1, acc, rdy, vld);
    step32(1, 32'h0000_0F00, 4'hC, 1, acc, rdy, vld);
    drain32(10);

    // 8-bit, three levels in one stage: latency 1, exhaustive operands.
    chk_lat = 1; lat_exp = 1;
    for (int v = 0; v < 256; v++) step8(1, 8'(v), 4'(v));
    for (int i = 0; i < 4; i++) step8(0, '0, '0);
    chk("drain8_empty", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
